// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared encodings for the forwarding/hazard unit.
//   SEL_RF        : select value meaning "read the register file"
//   sel_stage(k)  : select value for forwarding stage k (k = 0 is EX)
//   sel_wbq(n)    : select value for the delayed write-back data, n = NUM_FWD
//   hz_state_e    : load-use stall FSM states
// Used by hazard_port_match and hazard_fwd_unit (optional macro there:
// HAZ_PERF_CNT_EN).
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int SEL_RF = 0;

  // Counter width for the extra stall cycles; LOAD_LAT is limited to 1..7.
  localparam int CNT_W = 3;

  function automatic int sel_stage(input int k);
    return k + 1;
  endfunction

  function automatic int sel_wbq(input int num_fwd);
    return num_fwd + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_port_match.sv
// -----------------------------------------------------------------------------
// hazard_port_match
// Combinational priority encoder for one decode read port. Compares the port's
// source register against every forwarding stage and against the registered
// copy of last cycle's retiring write-back destination.
// Ports:
//   rd_addr_i  / rd_en_i   : source register of this port and its read enable
//   fwd_addr_i / fwd_wr_i  : destination register and write flag of each stage
//   wbq_addr_i / wbq_wr_i  : destination/write flag retired by WB last cycle
//   sel_o                  : unregistered select (SEL_RF, stage k+1, or WBQ)
//   ex_hit_o               : the winning match is stage 0 (EX)
// -----------------------------------------------------------------------------
module hazard_port_match
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int SELW    = 2
) (
  input  logic [REG_AW-1:0]         rd_addr_i,
  input  logic                      rd_en_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD-1:0]        fwd_wr_i,
  input  logic [REG_AW-1:0]         wbq_addr_i,
  input  logic                      wbq_wr_i,
  output logic [SELW-1:0]           sel_o,
  output logic                      ex_hit_o
);

  // x0 is hard-wired zero and must never be forwarded.
  logic rd_live;
  assign rd_live = rd_en_i && (rd_addr_i != '0);

  always_comb begin
    sel_o = SELW'(SEL_RF);
    // Delayed WB data is the weakest source; any live stage overrides it.
    if (rd_live && wbq_wr_i && (wbq_addr_i == rd_addr_i)) begin
      sel_o = SELW'(sel_wbq(NUM_FWD));
    end
    // Walk oldest to youngest so the youngest matching stage is written last.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (rd_live && fwd_wr_i[k] &&
          (fwd_addr_i[k*REG_AW +: REG_AW] == rd_addr_i)) begin
        sel_o = SELW'(sel_stage(k));
      end
    end
  end

  assign ex_hit_o = (sel_o == SELW'(sel_stage(0)));

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Forwarding and load-use hazard unit for the in-order pipelines.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   flush          : synchronous pipeline flush (clears selects and FSM)
//   id_valid       : decode holds a valid instruction
//   rd_addr, rd_en : decode source registers (port p at [p*REG_AW +: REG_AW])
//   fwd_addr, fwd_wr : destination register / write flag per stage (0 = EX)
//   ex_is_load     : EX instruction is a load
//   wb_data        : write-back data of the oldest stage
//   fwd_sel        : registered select per port (SELW bits each)
//   wb_data_q      : wb_data delayed one cycle
//   stall          : hold PC/IF/ID and bubble EX
//   dbg_state_o    : current stall FSM state (0 = IDLE, 1 = STALL)
// Optional: HAZ_PERF_CNT_EN adds saturating counters stall_cnt (cycles with
// stall high) and ld_haz_cnt (load-use hazards accepted in IDLE).
//
// Handshake: there is no valid/ready pair here; stall is a same-cycle
// combinational request to upstream, and fwd_sel is valid the cycle after the
// addresses are presented (decode holds its addresses while stalled).
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter  int NUM_RD   = 2,
  parameter  int NUM_FWD  = 2,
  parameter  int REG_AW   = 5,
  parameter  int XLEN     = 32,
  parameter  int LOAD_LAT = 1,
  localparam int SELW     = $clog2(NUM_FWD + 2)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_RD*REG_AW-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_wr,
  input  logic                      ex_is_load,
  input  logic [XLEN-1:0]           wb_data,
  output logic [NUM_RD*SELW-1:0]    fwd_sel,
  output logic [XLEN-1:0]           wb_data_q,
  output logic                      stall,
  output logic                      dbg_state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               ld_haz_cnt
`endif
);

  // The IDLE cycle of the hazard is the first stall cycle, so STALL only
  // covers the remaining LOAD_LAT-1 cycles: load cnt with LOAD_LAT-2.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  hz_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_RD*SELW-1:0]   sel_d;
  logic [NUM_RD*SELW-1:0]   fwd_sel_q;
  logic [NUM_RD-1:0]        ex_hit;
  logic [REG_AW-1:0]        wbq_addr_q;
  logic                     wbq_wr_q;
  logic                     ld_hit;
  logic                     stall_c;
  logic                     ld_acc;

  // ---------------------------------------------------------------------------
  // Per-port match
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    hazard_port_match #(
      .NUM_FWD (NUM_FWD),
      .REG_AW  (REG_AW),
      .SELW    (SELW)
    ) u_match (
      .rd_addr_i  (rd_addr[p*REG_AW +: REG_AW]),
      .rd_en_i    (rd_en[p]),
      .fwd_addr_i (fwd_addr),
      .fwd_wr_i   (fwd_wr),
      .wbq_addr_i (wbq_addr_q),
      .wbq_wr_i   (wbq_wr_q),
      .sel_o      (sel_d[p*SELW +: SELW]),
      .ex_hit_o   (ex_hit[p])
    );
  end

  assign ld_hit = id_valid & ex_is_load & (|ex_hit);

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    ld_acc  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_c = ld_hit;
          ld_acc  = ld_hit;
          if (ld_hit && (LOAD_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
        STALL: begin
          stall_c = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Gate with rstn so stall drops the moment reset asserts, even if the
  // current inputs would otherwise raise a load-use hit.
  assign stall       = rstn & stall_c;
  assign dbg_state_o = state_q;
  assign fwd_sel     = fwd_sel_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fwd_sel_q  <= '0;
      wb_data_q  <= '0;
      wbq_addr_q <= '0;
      wbq_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fwd_sel_q  <= flush ? '0 : sel_d;
      wb_data_q  <= wb_data;
      wbq_addr_q <= fwd_addr[(NUM_FWD-1)*REG_AW +: REG_AW];
      wbq_wr_q   <= fwd_wr[NUM_FWD-1];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters: saturating, cleared only by rstn.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;
  logic [31:0] ld_haz_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q  <= '0;
      ld_haz_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ld_acc && (ld_haz_cnt_q != '1)) begin
        ld_haz_cnt_q <= ld_haz_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign ld_haz_cnt = ld_haz_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 2;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;
  localparam int SELW    = 2;
  localparam int SW      = NUM_RD * SELW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                      flush;
  logic                      id_valid;
  logic [NUM_RD*REG_AW-1:0]  rd_addr;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr;
  logic [NUM_FWD-1:0]        fwd_wr;
  logic                      ex_is_load;
  logic [XLEN-1:0]           wb_data;

  logic [SW-1:0]   fwd_sel3, fwd_sel1;
  logic [XLEN-1:0] wb_data_q3, wb_data_q1;
  logic            stall3, stall1;
  logic            dbg3, dbg1;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]     sc3, lc3, sc1, lc1;
`endif

  // Main DUT: three-cycle load-use latency.
  hazard_fwd_unit #(
    .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .XLEN(XLEN), .LOAD_LAT(3)
  ) dut3 (
    .clk(clk), .rstn(rstn), .flush(flush), .id_valid(id_valid),
    .rd_addr(rd_addr), .rd_en(rd_en), .fwd_addr(fwd_addr), .fwd_wr(fwd_wr),
    .ex_is_load(ex_is_load), .wb_data(wb_data),
    .fwd_sel(fwd_sel3), .wb_data_q(wb_data_q3), .stall(stall3), .dbg_state_o(dbg3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc3), .ld_haz_cnt(lc3)
`endif
  );

  // Companion DUT on the same inputs: single-cycle load-use latency.
  hazard_fwd_unit #(
    .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .XLEN(XLEN), .LOAD_LAT(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush), .id_valid(id_valid),
    .rd_addr(rd_addr), .rd_en(rd_en), .fwd_addr(fwd_addr), .fwd_wr(fwd_wr),
    .ex_is_load(ex_is_load), .wb_data(wb_data),
    .fwd_sel(fwd_sel1), .wb_data_q(wb_data_q1), .stall(stall1), .dbg_state_o(dbg1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc1), .ld_haz_cnt(lc1)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [SW-1:0]   exp_q[$];
  logic [XLEN-1:0] exp_wb_q[$];
  logic [REG_AW-1:0] m_prev_addr;
  logic              m_prev_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference select: first (youngest) matching stage, else last cycle's
  // retired WB destination, else register file. x0 never matches.
  function automatic logic [SW-1:0] model_sel();
    logic [SW-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [REG_AW-1:0] a;
      logic [SELW-1:0]   s;
      logic              found;
      a     = rd_addr[p*REG_AW +: REG_AW];
      s     = 2'd0;
      found = 1'b0;
      if (rd_en[p] && a != 0) begin
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!found && fwd_wr[k] && fwd_addr[k*REG_AW +: REG_AW] == a) begin
            s     = SELW'(k + 1);
            found = 1'b1;
          end
        end
        if (!found && m_prev_wr && m_prev_addr == a) s = SELW'(NUM_FWD + 1);
      end
      r[p*SELW +: SELW] = s;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    flush      = 1'b0;
    id_valid   = 1'b1;
    rd_addr    = '0;
    rd_en      = '0;
    fwd_addr   = '0;
    fwd_wr     = '0;
    ex_is_load = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [REG_AW-1:0] a, input logic en);
    rd_addr[p*REG_AW +: REG_AW] = a;
    rd_en[p] = en;
  endtask

  task automatic set_stage(input int k, input logic [REG_AW-1:0] a, input logic wr);
    fwd_addr[k*REG_AW +: REG_AW] = a;
    fwd_wr[k] = wr;
  endtask

  // One clock with the current inputs: push expectations, check the
  // combinational stall mid-cycle, then pop and check registered outputs.
  task automatic cycle(input string tag, input logic exp3, input logic chk1, input logic exp1);
    logic [SW-1:0]   e;
    logic [XLEN-1:0] ew;
    exp_q.push_back(flush ? '0 : model_sel());
    exp_wb_q.push_back(wb_data);
    @(negedge clk);
    check({tag, "/stall3"}, 64'(stall3), 64'(exp3));
    if (chk1) check({tag, "/stall1"}, 64'(stall1), 64'(exp1));
    @(posedge clk);
    #1;
    m_prev_addr = fwd_addr[(NUM_FWD-1)*REG_AW +: REG_AW];
    m_prev_wr   = fwd_wr[NUM_FWD-1];
    if (exp_q.size() == 0 || exp_wb_q.size() == 0) begin
      check({tag, "/queue_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e  = exp_q.pop_front();
      ew = exp_wb_q.pop_front();
      check({tag, "/sel3"}, 64'(fwd_sel3), 64'(e));
      check({tag, "/sel1"}, 64'(fwd_sel1), 64'(e));
      check({tag, "/wbq"},  64'(wb_data_q3), 64'(ew));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/stall3"}, 64'(stall3), 64'd0);
    check({tag, "/stall1"}, 64'(stall1), 64'd0);
    check({tag, "/sel3"},   64'(fwd_sel3), 64'd0);
    check({tag, "/sel1"},   64'(fwd_sel1), 64'd0);
    check({tag, "/wbq3"},   64'(wb_data_q3), 64'd0);
    check({tag, "/wbq1"},   64'(wb_data_q1), 64'd0);
    check({tag, "/state3"}, 64'(dbg3), 64'd0);
`ifdef HAZ_PERF_CNT_EN
    check({tag, "/sc3"}, 64'(sc3), 64'd0);
    check({tag, "/lc3"}, 64'(lc3), 64'd0);
`endif
  endtask

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [XLEN-1:0] d;
    rstn = 1'b0;
    clear_inputs();
    wb_data     = '0;
    m_prev_addr = '0;
    m_prev_wr   = 1'b0;

    // Reset state, with a load-use pattern on the inputs to prove gating.
    set_port(0, 5'd3, 1'b1); set_stage(0, 5'd3, 1'b1); ex_is_load = 1'b1;
    wb_data = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clear_inputs();
    wb_data = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // RAW from EX on port 0.
    set_port(0, 5'd5, 1'b1); set_stage(0, 5'd5, 1'b1);
    wb_data = $urandom_range(1, 32'hFFFF);
    cycle("raw_ex", 1'b0, 1'b1, 1'b0);
    clear_inputs();
    cycle("raw_ex_off", 1'b0, 1'b1, 1'b0);

    // Youngest wins when both stages write x7; then x0 never forwards.
    set_port(1, 5'd7, 1'b1); set_stage(0, 5'd7, 1'b1); set_stage(1, 5'd7, 1'b1);
    cycle("prio", 1'b0, 1'b1, 1'b0);
    set_port(1, 5'd0, 1'b1); set_stage(0, 5'd0, 1'b1); set_stage(1, 5'd0, 1'b1);
    cycle("x0", 1'b0, 1'b1, 1'b0);

    // WB retire forward: stage 1 writes x9, next cycle port 0 reads x9.
    clear_inputs();
    d = $urandom_range(32'h1000, 32'hFFFF_FFFF);
    wb_data = d;
    set_stage(1, 5'd9, 1'b1);
    cycle("wbq_t", 1'b0, 1'b1, 1'b0);
    clear_inputs();
    set_port(0, 5'd9, 1'b1);
    cycle("wbq_t1", 1'b0, 1'b1, 1'b0);
    check("wbq_sel_value", 64'(fwd_sel3[1:0]), 64'd3);
    check("wbq_data_value", 64'(wb_data_q3), 64'(d));

    // A live stage beats the delayed WB copy of the same register.
    clear_inputs();
    set_stage(1, 5'd9, 1'b1);
    wb_data = $urandom_range(0, 32'hFFFF);
    cycle("wbq_pre", 1'b0, 1'b1, 1'b0);
    clear_inputs();
    set_port(0, 5'd9, 1'b1); set_stage(0, 5'd9, 1'b1);
    cycle("wbq_vs_ex", 1'b0, 1'b1, 1'b0);

    // Load in EX whose match is only stage 1: no load-use hazard.
    clear_inputs();
    set_port(0, 5'd4, 1'b1); set_stage(1, 5'd4, 1'b1); ex_is_load = 1'b1;
    cycle("ld_st1", 1'b0, 1'b1, 1'b0);

    // id_valid low: no stall, selects still update.
    clear_inputs();
    id_valid = 1'b0;
    set_port(1, 5'd12, 1'b1); set_stage(0, 5'd12, 1'b1); ex_is_load = 1'b1;
    cycle("no_valid", 1'b0, 1'b1, 1'b0);

    // Load-use on port 1 with LOAD_LAT=3: stall for exactly three cycles,
    // ex_is_load held high throughout.
    clear_inputs();
    set_port(1, 5'd3, 1'b1); set_stage(0, 5'd3, 1'b1); ex_is_load = 1'b1;
    cycle("lu_t", 1'b1, 1'b1, 1'b1);
    check("lu_state_t1", 64'(dbg3), 64'd1);
    cycle("lu_t1", 1'b1, 1'b0, 1'b0);
    cycle("lu_t2", 1'b1, 1'b0, 1'b0);
    set_stage(0, 5'd3, 1'b0);
    cycle("lu_t3", 1'b0, 1'b1, 1'b0);
    check("lu_state_t4", 64'(dbg3), 64'd0);

    // Flush during stall.
    clear_inputs();
    set_port(0, 5'd6, 1'b1); set_stage(0, 5'd6, 1'b1); ex_is_load = 1'b1;
    cycle("fl_t", 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    cycle("fl_t1", 1'b0, 1'b1, 1'b0);
    check("fl_state", 64'(dbg3), 64'd0);
    flush = 1'b0;
    set_stage(0, 5'd6, 1'b0);
    cycle("fl_t2", 1'b0, 1'b1, 1'b0);

    // Flush together with a fresh hit: no stall, no STALL state entered.
    set_stage(0, 5'd6, 1'b1);
    flush = 1'b1;
    cycle("fl_sim", 1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    set_stage(0, 5'd6, 1'b0);
    cycle("fl_sim2", 1'b0, 1'b1, 1'b0);

    // Reset mid-stall, from a freshly reset unit so counters are known.
    clear_inputs();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    m_prev_addr = '0;
    m_prev_wr   = 1'b0;
    set_port(0, 5'd11, 1'b1); set_stage(0, 5'd11, 1'b1); ex_is_load = 1'b1;
    cycle("rm_t", 1'b1, 1'b1, 1'b1);
    cycle("rm_t1", 1'b1, 1'b1, 1'b1);
    #2;
    check("rm_pre_stall3", 64'(stall3), 64'd1);
    check("rm_pre_state3", 64'(dbg3), 64'd1);
`ifdef HAZ_PERF_CNT_EN
    check("rm_pre_sc3", 64'(sc3), 64'd2);
    check("rm_pre_lc3", 64'(lc3), 64'd1);
    check("rm_pre_sc1", 64'(sc1), 64'd2);
    check("rm_pre_lc1", 64'(lc1), 64'd2);
`endif
    rstn = 1'b0;
    #1;
    check_reset_outputs("rm_reset");
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    m_prev_addr = '0;
    m_prev_wr   = 1'b0;
    wb_data = $urandom_range(0, 32'hFFFF);
    cycle("rm_after", 1'b0, 1'b1, 1'b0);

    // Final report
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
